mult_arbiter: RTL and testbench

//   Round-robin arbiter sharing one sequential signed multiplier (en/done handshake, e.g. booth_mult)

---
 rtl/mult_arbiter.sv | 127 ++++++++++++
 tb/tb_mult_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential signed multiplier (en/done handshake)
// among NREQ requesters, with a watchdog that aborts jobs whose multiplier never finishes.
module mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_m,
    output logic                      rsp_err,
    output logic                      mul_en,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    input  logic                      mul_done,
    input  logic [2*WIDTH-1:0]        mul_m,
    output logic                      busy
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Handshake: a request transfers on a rising clk edge where req_valid[i] & req_ready[i];
    // req_ready is only offered in IDLE while the multiplier shows done low.
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_idx;
    int               scan_sum;

    // Scan from ptr upward with wrap; first pending line wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        scan_sum    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = int'(ptr) + k;
            if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
            scan_idx = ID_W'(scan_sum);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && !mul_done && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_m     <= '0;
            rsp_err   <= 1'b0;
            mul_en    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        mul_a  <= req_a[grant_idx*WIDTH +: WIDTH];
                        mul_b  <= req_b[grant_idx*WIDTH +: WIDTH];
                        id     <= grant_idx;
                        cnt    <= '0;
                        mul_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Completion takes priority over the watchdog in the same cycle.
                    if (mul_done) begin
                        rsp_m     <= mul_m;
                        rsp_id    <= id;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        mul_en    <= 1'b0;
                        state     <= DRAIN;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_m     <= '0;
                        rsp_id    <= id;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        mul_en    <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!mul_done) begin
                        ptr   <= (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    mul_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural latency multiplier, directed steps with random operands,
// and a scoreboard that predicts grant order and products from the arbitration rules.
module tb_mult_arbiter;
    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;
    localparam int EXP_W   = ID_W + 1 + 2*WIDTH;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [2*WIDTH-1:0]    rsp_m;
    logic                  rsp_err;
    logic                  mul_en;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_m;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_m(rsp_m),
        .rsp_err(rsp_err), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_m(mul_m), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier model: done rises lat cycles after en, held until en drops
    int lat = 3;
    bit stub = 1'b0;
    int lat_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0;
            mul_m    <= '0;
            lat_cnt  <= 0;
        end else if (!mul_en) begin
            mul_done <= 1'b0;
            lat_cnt  <= 0;
        end else if (!mul_done && !stub) begin
            if (lat_cnt >= lat - 1) begin
                mul_done <= 1'b1;
                mul_m    <= 16'(int'($signed(mul_a)) * int'($signed(mul_b)));
            end
            lat_cnt <= lat_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        return 16'(ai * bi);
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // scoreboard
    logic [EXP_W-1:0]   exp_q[$];
    int                 grant_log[$];
    logic [2*WIDTH-1:0] rsp_log[$];
    int                 model_ptr = 0;
    int                 ready_cycles = 0;
    int                 en_cycles = 0;
    int                 g;
    logic               prev_rsp = 1'b0;
    logic [WIDTH-1:0]   cur_a, cur_b;
    logic [EXP_W-1:0]   e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_ptr = 0;
            prev_rsp  = 1'b0;
        end else begin
            if (busy) check("ready_while_busy", req_ready, 0);
            if (req_ready != 0) begin
                ready_cycles++;
                g = exp_grant(req_valid, model_ptr);
                check("grant_onehot", req_ready, (g < 0) ? 0 : (1 << g));
                if ((req_valid & req_ready) != 0 && g >= 0) begin
                    cur_a = req_a[g*WIDTH +: WIDTH];
                    cur_b = req_b[g*WIDTH +: WIDTH];
                    if (stub) exp_q.push_back({ID_W'(g), 1'b1, 16'h0});
                    else      exp_q.push_back({ID_W'(g), 1'b0, ref_mul(cur_a, cur_b)});
                    grant_log.push_back(g);
                    en_cycles = 0;
                end
            end
            if (mul_en) begin
                en_cycles++;
                check("mul_ops_stable", {mul_a, mul_b}, {cur_a, cur_b});
            end
            if (rsp_valid) begin
                check("rsp_not_b2b", prev_rsp, 0);
                check("mul_en_low_drain", mul_en, 0);
                rsp_log.push_back(rsp_m);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", rsp_id, e[EXP_W-1 -: ID_W]);
                    check("rsp_err", rsp_err, e[2*WIDTH]);
                    check("rsp_m", rsp_m, e[2*WIDTH-1:0]);
                    if (e[2*WIDTH]) check("timeout_cycles", en_cycles, TIMEOUT);
                    model_ptr = (int'(e[EXP_W-1 -: ID_W]) + 1) % NREQ;
                end
            end
            prev_rsp = rsp_valid;
        end
    end

    // driver tasks
    logic [NREQ-1:0] hold_mask = '0;

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*WIDTH +: WIDTH] = 8'(a);
        req_b[i*WIDTH +: WIDTH] = 8'(b);
        req_valid[i] = 1'b1;
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                req_valid[i] = 1'b0;
                if (hold_mask[i]) set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
        end
    endtask

    task automatic run_until_quiet(input int max_cycles);
        int n = 0;
        int quiet = 0;
        while (quiet < 2 && n < max_cycles) begin
            step();
            n++;
            if (req_valid == 0 && !busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        check("quiet_in_time", n < max_cycles, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_ready"}, req_ready, 0);
        check({pfx, "_rsp_valid"}, rsp_valid, 0);
        check({pfx, "_rsp_id"}, rsp_id, 0);
        check({pfx, "_rsp_m"}, rsp_m, 0);
        check({pfx, "_rsp_err"}, rsp_err, 0);
        check({pfx, "_mul_en"}, mul_en, 0);
        check({pfx, "_mul_a"}, mul_a, 0);
        check({pfx, "_mul_b"}, mul_b, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    task automatic check_grants(input string tag, input int exp_seq[6], input int n);
        check({tag, "_count_ok"}, grant_log.size() >= n, 1);
        for (int i = 0; i < n; i++)
            if (i < grant_log.size()) check(tag, grant_log[i], exp_seq[i]);
    endtask

    initial begin
        int seq[6];
        logic [2*WIDTH-1:0] exp_m[3];
        int n;

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single request
        ready_cycles = 0;
        grant_log.delete();
        set_req(0, 1, 1);
        run_until_quiet(200);
        check("single_ready_cycles", ready_cycles, 1);
        seq = '{0, 0, 0, 0, 0, 0};
        check_grants("single_grant", seq, 1);

        // all four pending from reset
        do_reset();
        grant_log.delete();
        rsp_log.delete();
        lat = 5;
        set_req(0, 1, -1);
        set_req(1, -1, -1);
        set_req(2, -10, -100);
        set_req(3, 10, -5);
        run_until_quiet(400);
        seq = '{0, 1, 2, 3, 0, 0};
        check_grants("all4_grant", seq, 4);
        check("all4_rsp_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            check("all4_m0", rsp_log[0], 16'hFFFF);
            check("all4_m1", rsp_log[1], 16'h0001);
            check("all4_m2", rsp_log[2], 16'd1000);
            check("all4_m3", rsp_log[3], 16'hFFCE);
        end

        // req0 held continuously against req2
        grant_log.delete();
        lat = 2;
        hold_mask = 4'b0101;
        set_req(0, 3, 4);
        set_req(2, -7, 9);
        n = 0;
        while (grant_log.size() < 6 && n < 300) begin
            step();
            n++;
        end
        hold_mask = '0;
        run_until_quiet(400);
        seq = '{0, 2, 0, 2, 0, 2};
        check_grants("alt_grant", seq, 6);

        // corner operands
        do_reset();
        rsp_log.delete();
        lat = 8;
        set_req(0, -128, -128);
        set_req(1, -128, 127);
        set_req(2, 100, 127);
        run_until_quiet(400);
        exp_m = '{16'h4000, 16'(-16256), 16'd12700};
        check("corner_rsp_count", rsp_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < rsp_log.size()) check("corner_m", rsp_log[i], exp_m[i]);

        // random traffic
        for (int it = 0; it < 25; it++) begin
            lat = int'($urandom_range(1, 12));
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if (req_valid == 0) set_req(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 255)), 3);
            run_until_quiet(2000);
        end

        // watchdog abort
        stub = 1'b1;
        rsp_log.delete();
        set_req(1, 5, 6);
        run_until_quiet(300);
        stub = 1'b0;
        check("timeout_rsp_count", rsp_log.size(), 1);
        check("timeout_idle", busy, 0);

        // reset in the middle of a job
        lat = 10;
        set_req(3, 7, 7);
        n = 0;
        while (!mul_en && n < 20) begin
            step();
            n++;
        end
        check("midrst_started", mul_en, 1);
        step();
        step();
        #2;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        rsp_log.delete();
        set_req(2, -3, 9);
        run_until_quiet(200);
        seq = '{2, 0, 0, 0, 0, 0};
        check_grants("after_rst_grant", seq, 1);
        check("after_rst_rsp_count", rsp_log.size(), 1);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
